// File: rtl/perf_pkg.sv
// Shared definitions for the run-statistics controller.
package perf_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int FRAC_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DIV,
    ST_DUMP,
    ST_DONE
  } state_e;

  localparam logic [1:0] DUMP_ID_CYCLES = 2'd0;
  localparam logic [1:0] DUMP_ID_INSTR  = 2'd1;
  localparam logic [1:0] DUMP_ID_STALLS = 2'd2;
  localparam logic [1:0] DUMP_ID_IPC    = 2'd3;

endpackage

// File: rtl/perf_monitor_ctrl_if.sv
// Result stream from the controller to the stats/print sink.
interface perf_monitor_ctrl_if
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             dump_valid;
  logic             dump_ready;
  logic [1:0]       dump_id;
  logic [CNT_W-1:0] dump_data;

  modport master (output dump_valid, dump_id, dump_data, input dump_ready);
  modport slave  (input dump_valid, dump_id, dump_data, output dump_ready);

endinterface

// File: rtl/perf_seq_divider.sv
// Restoring divider, one quotient bit per cycle. go loads the operands;
// q_valid pulses DVD_W cycles later and quotient holds until the next go.
// A zero divisor yields an all-ones quotient naturally (every trial subtract succeeds).
module perf_seq_divider
  import perf_pkg::*;
#(
  parameter int DVD_W = CNT_W_DEF + FRAC_W_DEF,
  parameter int DVS_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             q_valid,
  output logic [DVD_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [DVD_W-1:0] shq_q, shq_d;
  logic             busy_q, busy_d, qv_q, qv_d;
  logic [DVS_W:0]   rem_sh;
  logic [DVS_W-1:0] diff;

  // Next-state: load on go, otherwise shift one dividend bit into the remainder per cycle
  always_comb begin
    rem_sh = {rem_q, shq_q[DVD_W-1]};
    diff   = rem_sh[DVS_W-1:0] - dvs_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    shq_d  = shq_q;
    busy_d = busy_q;
    qv_d   = 1'b0;
    if (go) begin
      cnt_d  = CW'(DVD_W);
      rem_d  = '0;
      dvs_d  = divisor;
      shq_d  = dividend;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = diff;
        shq_d = {shq_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DVS_W-1:0];
        shq_d = {shq_q[DVD_W-2:0], 1'b0};
      end
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        qv_d   = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      shq_q  <= '0;
      busy_q <= 1'b0;
      qv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      shq_q  <= shq_d;
      busy_q <= busy_d;
      qv_q   <= qv_d;
    end
  end

  assign busy     = busy_q;
  assign q_valid  = qv_q;
  assign quotient = shq_q;

endmodule

// File: rtl/perf_monitor_ctrl.sv
// Run-statistics controller: counts cycles/retires/stalls between start and
// halt, drains late retirements, divides for IPC and streams four result words.
module perf_monitor_ctrl
  import perf_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                instr_retire,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  perf_monitor_ctrl_if.master dump
);

  localparam int DVD_W = CNT_W + FRAC_W;
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d, stl_q, stl_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             dv_q, dv_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] data_q, data_d;

  logic             div_go, div_busy, div_qv;
  logic [DVD_W-1:0] div_quot;
  logic [CNT_W-1:0] ipc;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v, logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // IPC above CNT_W integer+fraction bits clamps to all-ones
  assign ipc = (|div_quot[DVD_W-1:CNT_W]) ? CNT_MAX : div_quot[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] word_sel(logic [1:0] id);
    case (id)
      DUMP_ID_CYCLES: return cyc_q;
      DUMP_ID_INSTR:  return ins_q;
      DUMP_ID_STALLS: return stl_q;
      default:        return ipc;
    endcase
  endfunction

  // FSM, counters and dump mux next-state
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    stl_d   = stl_q;
    drn_d   = drn_q;
    dv_d    = dv_q;
    id_d    = id_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cyc_d   = '0;
          ins_d   = '0;
          stl_d   = '0;
        end
      end
      ST_RUN: begin
        cyc_d = sat_inc(cyc_q, 1'b1);
        ins_d = sat_inc(ins_q, instr_retire);
        stl_d = sat_inc(stl_q, stall);
        if (halt) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_DRAIN;
            drn_d   = DRN_W'(DRAIN_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        ins_d = sat_inc(ins_q, instr_retire);
        drn_d = drn_q - DRN_W'(1);
        if (drn_q == DRN_W'(1)) state_d = ST_DIV;
      end
      ST_DIV: begin
        if (div_qv && !div_busy) begin
          state_d = ST_DUMP;
          dv_d    = 1'b1;
          id_d    = DUMP_ID_CYCLES;
          data_d  = cyc_q;
        end
      end
      ST_DUMP: begin
        if (dump.dump_ready) begin
          if (id_q == DUMP_ID_IPC) begin
            dv_d    = 1'b0;
            state_d = ST_DONE;
          end else begin
            id_d   = id_q + 2'd1;
            data_d = word_sel(id_q + 2'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
             (state_d == ST_DIV) || (state_d == ST_DUMP);
    done_d = (state_d == ST_DONE);
  end

  // Launch on the DIV entry edge using the final counter values
  assign div_go = (state_d == ST_DIV) && (state_q != ST_DIV);

  perf_seq_divider #(.DVD_W(DVD_W), .DVS_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend ({ins_d, {FRAC_W{1'b0}}}),
    .divisor  (cyc_d),
    .busy     (div_busy),
    .q_valid  (div_qv),
    .quotient (div_quot)
  );

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
      stl_q   <= '0;
      drn_q   <= '0;
      dv_q    <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      stl_q   <= stl_d;
      drn_q   <= drn_d;
      dv_q    <= dv_d;
      id_q    <= id_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dump.dump_valid = dv_q;
  assign dump.dump_id    = id_q;
  assign dump.dump_data  = data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
